// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one data-memory port among
// num_req_p cores, with a single transaction outstanding at a time.
module dmem_arbiter #(
  parameter int num_req_p      = 4,
  parameter int req_id_width_p = $clog2(num_req_p)
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic [num_req_p-1:0]      req_valid_i,
  input  logic [num_req_p*32-1:0]   req_addr_i,
  input  logic [num_req_p*32-1:0]   req_wdata_i,
  input  logic [num_req_p-1:0]      req_wen_i,
  input  logic [num_req_p-1:0]      req_byte_i,
  output logic [num_req_p-1:0]      req_yumi_o,
  output logic [num_req_p-1:0]      resp_valid_o,
  output logic [31:0]               resp_data_o,
  input  logic [num_req_p-1:0]      resp_yumi_i,
  output logic                      mem_valid_o,
  output logic [31:0]               mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  output logic                      mem_wen_o,
  output logic                      mem_byte_o,
  input  logic                      mem_yumi_i,
  input  logic                      mem_resp_valid_i,
  input  logic [31:0]               mem_resp_data_i,
  output logic                      mem_resp_yumi_o,
  output logic [req_id_width_p-1:0] grant_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam logic [req_id_width_p-1:0] last_idx = req_id_width_p'(num_req_p - 1);

  state_e                    state_r, state_n;
  logic [req_id_width_p-1:0] grant_r, grant_n;
  logic [req_id_width_p-1:0] rr_ptr_r, rr_ptr_n;
  logic [req_id_width_p-1:0] winner, scan_idx, grant_inc;
  logic                      found;
  logic [31:0]               addr_a  [num_req_p];
  logic [31:0]               wdata_a [num_req_p];

  // Unpack the flat per-core buses into indexable arrays.
  genvar g;
  generate
    for (g = 0; g < num_req_p; g++) begin : g_unpack
      assign addr_a[g]  = req_addr_i[g*32 +: 32];
      assign wdata_a[g] = req_wdata_i[g*32 +: 32];
    end
  endgenerate

  // Round-robin scan: first valid requester starting at rr_ptr_r, wrapping mod num_req_p.
  always_comb begin
    found    = 1'b0;
    winner   = rr_ptr_r;
    scan_idx = rr_ptr_r;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (!found && req_valid_i[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
      scan_idx = (scan_idx == last_idx) ? '0 : scan_idx + 1'b1;
    end
  end

  // Pointer advance past the current owner, wrapping for non-power-of-two counts.
  always_comb begin
    grant_inc = (grant_r == last_idx) ? '0 : grant_r + 1'b1;
  end

  // Next-state and handshake outputs. Reset is synchronous, so every handshake
  // is suppressed combinationally during the reset cycle itself.
  always_comb begin
    state_n         = state_r;
    grant_n         = grant_r;
    rr_ptr_n        = rr_ptr_r;
    req_yumi_o      = '0;
    resp_valid_o    = '0;
    mem_valid_o     = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    mem_wen_o       = 1'b0;
    mem_byte_o      = 1'b0;
    mem_resp_yumi_o = 1'b0;
    if (n_reset) begin
      unique case (state_r)
        IDLE: begin
          if (found) begin
            grant_n = winner;
            state_n = REQ;
          end
        end
        REQ: begin
          mem_valid_o         = 1'b1;
          mem_addr_o          = addr_a[grant_r];
          mem_wdata_o         = wdata_a[grant_r];
          mem_wen_o           = req_wen_i[grant_r];
          mem_byte_o          = req_byte_i[grant_r];
          req_yumi_o[grant_r] = mem_yumi_i;
          if (mem_yumi_i) state_n = RESP;
        end
        RESP: begin
          resp_valid_o[grant_r] = mem_resp_valid_i;
          mem_resp_yumi_o       = mem_resp_valid_i & resp_yumi_i[grant_r];
          if (mem_resp_yumi_o) begin
            state_n  = IDLE;
            rr_ptr_n = grant_inc;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_r  <= IDLE;
      grant_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r  <= state_n;
      grant_r  <= grant_n;
      rr_ptr_r <= rr_ptr_n;
    end
  end

  assign resp_data_o = mem_resp_data_i;
  assign grant_o     = n_reset ? grant_r : '0;
  assign busy_o      = n_reset && (state_r != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized transactions against a
// round-robin reference model.
module tb_dmem_arbiter;

  logic         clk = 1'b0;
  logic         n_reset;
  logic [3:0]   req_valid_i;
  logic [127:0] req_addr_i, req_wdata_i;
  logic [3:0]   req_wen_i, req_byte_i;
  logic [3:0]   req_yumi_o, resp_valid_o;
  logic [31:0]  resp_data_o;
  logic [3:0]   resp_yumi_i;
  logic         mem_valid_o;
  logic [31:0]  mem_addr_o, mem_wdata_o;
  logic         mem_wen_o, mem_byte_o;
  logic         mem_yumi_i, mem_resp_valid_i;
  logic [31:0]  mem_resp_data_i;
  logic         mem_resp_yumi_o;
  logic [1:0]   grant_o;
  logic         busy_o;

  int errors = 0;
  int checks = 0;
  int rr     = 0;

  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic [3:0]  wen, byt;

  always #5 clk = ~clk;

  dmem_arbiter #(.num_req_p(4)) dut (
    .clk(clk), .n_reset(n_reset),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_wen_i(req_wen_i), .req_byte_i(req_byte_i), .req_yumi_o(req_yumi_o),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wen_o(mem_wen_o), .mem_byte_o(mem_byte_o), .mem_yumi_i(mem_yumi_i),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
    .mem_resp_yumi_o(mem_resp_yumi_o), .grant_o(grant_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Owner must keep its request valid while the memory request is pending.
  always begin
    @(negedge clk);
    #2;
    if (n_reset && mem_valid_o) begin
      assert (req_valid_i[grant_o]) else begin
        errors++;
        $error("FAIL proto owner dropped req_valid_i in REQ");
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference model: first valid core scanning from rr upward, modulo 4.
  function automatic int pick(input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      if (((v >> ((rr + k) % 4)) & 4'b1) != 4'b0) return (rr + k) % 4;
    end
    return -1;
  endfunction

  task automatic set_fields();
    req_addr_i  = {addr[3], addr[2], addr[1], addr[0]};
    req_wdata_i = {wdata[3], wdata[2], wdata[1], wdata[0]};
    req_wen_i   = wen;
    req_byte_i  = byt;
  endtask

  task automatic rand_fields();
    for (int k = 0; k < 4; k++) begin
      addr[k]  = $urandom;
      wdata[k] = $urandom;
    end
    wen = 4'($urandom);
    byt = 4'($urandom);
    set_fields();
  endtask

  // One full transaction from IDLE; entered and left at a falling edge with the DUT idle.
  task automatic do_txn(input logic [3:0] valid, input int ydly, input int rdly,
                        input int cdly, input bit early, input logic [31:0] rdata,
                        output int g_obs);
    int         w;
    logic [3:0] oh;
    w  = pick(valid);
    oh = 4'b1 << w;
    req_valid_i = valid;
    #1;
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_memv", 32'(mem_valid_o), 0);
    chk("idle_yumi", 32'(req_yumi_o), 0);
    @(negedge clk);
    g_obs = int'(grant_o);
    for (int c = 0; c <= ydly; c++) begin
      mem_yumi_i = (c == ydly);
      if (early && c == ydly) begin
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = rdata;
      end
      #1;
      chk("req_grant", 32'(grant_o), w);
      chk("req_busy", 32'(busy_o), 1);
      chk("req_memv", 32'(mem_valid_o), 1);
      chk("req_addr", mem_addr_o, addr[w]);
      chk("req_wdata", mem_wdata_o, wdata[w]);
      chk("req_wen", 32'(mem_wen_o), 32'(wen[w]));
      chk("req_byte", 32'(mem_byte_o), 32'(byt[w]));
      chk("req_yumi", 32'(req_yumi_o), (c == ydly) ? 32'(oh) : 0);
      chk("req_respv", 32'(resp_valid_o), 0);
      chk("req_mresp_yumi", 32'(mem_resp_yumi_o), 0);
      @(negedge clk);
    end
    mem_yumi_i = 1'b0;
    for (int c = 0; c < (early ? 0 : rdly); c++) begin
      resp_yumi_i = 4'($urandom) & ~oh;
      #1;
      chk("wait_respv", 32'(resp_valid_o), 0);
      chk("wait_mresp_yumi", 32'(mem_resp_yumi_o), 0);
      chk("wait_memv", 32'(mem_valid_o), 0);
      chk("wait_grant", 32'(grant_o), w);
      @(negedge clk);
    end
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = rdata;
    for (int c = 0; c <= cdly; c++) begin
      resp_yumi_i = (c == cdly) ? (oh | 4'($urandom)) : (4'($urandom) & ~oh);
      #1;
      chk("resp_valid", 32'(resp_valid_o), 32'(oh));
      chk("resp_data", resp_data_o, rdata);
      chk("resp_mresp_yumi", 32'(mem_resp_yumi_o), (c == cdly) ? 1 : 0);
      chk("resp_req_yumi", 32'(req_yumi_o), 0);
      chk("resp_grant", 32'(grant_o), w);
      @(negedge clk);
    end
    mem_resp_valid_i = 1'b0;
    resp_yumi_i      = '0;
    req_valid_i      = '0;
    rr = (w + 1) % 4;
    chk("rr_ptr", 32'(dut.rr_ptr_r), rr);
  endtask

  initial begin
    int         g;
    int         w;
    logic [3:0] oh;
    n_reset          = 1'b0;
    req_valid_i      = '1;
    resp_yumi_i      = '0;
    mem_yumi_i       = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = 32'h1234_5678;
    rand_fields();

    // Reset held two cycles with every core requesting.
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_yumi", 32'(req_yumi_o), 0);
      chk("rst_respv", 32'(resp_valid_o), 0);
      chk("rst_memv", 32'(mem_valid_o), 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_wdata", mem_wdata_o, 0);
      chk("rst_wen", 32'(mem_wen_o), 0);
      chk("rst_byte", 32'(mem_byte_o), 0);
      chk("rst_mresp_yumi", 32'(mem_resp_yumi_o), 0);
      chk("rst_grant", 32'(grant_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_rdata", resp_data_o, 32'h1234_5678);
    end
    @(negedge clk);
    n_reset     = 1'b1;
    req_valid_i = '0;
    rr          = 0;

    // Fairness: all cores continuously valid.
    for (int i = 0; i < 8; i++) begin
      do_txn(4'hF, 0, 0, 0, 1'b0, $urandom, g);
      chk("rr_order", g, i % 4);
    end

    // Single load from core 2.
    addr[2] = 32'h40;
    wen[2]  = 1'b0;
    set_fields();
    do_txn(4'b0100, 0, 2, 0, 1'b0, 32'hDEAD_BEEF, g);
    chk("load_grant", g, 2);
    chk("load_rr", 32'(dut.rr_ptr_r), 3);

    // Wrap and skip with only cores 1 and 3 valid.
    do_txn(4'b1010, 0, 1, 0, 1'b0, $urandom, g);
    chk("wrap_g3", g, 3);
    do_txn(4'b1010, 0, 1, 0, 1'b0, $urandom, g);
    chk("wrap_g1", g, 1);

    // Memory backpressure and delayed core response accept.
    rand_fields();
    do_txn(4'b0001, 5, 1, 3, 1'b0, $urandom, g);

    // Memory response raised in the same cycle as mem_yumi_i.
    do_txn(4'b0110, 1, 0, 1, 1'b1, $urandom, g);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      rand_fields();
      do_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), 1'($urandom), $urandom, g);
    end

    // Reset asserted while in RESP with a response being offered.
    rand_fields();
    req_valid_i = 4'b0010;
    w  = pick(4'b0010);
    oh = 4'b1 << w;
    @(negedge clk);
    mem_yumi_i = 1'b1;
    #1;
    chk("mid_req_yumi", 32'(req_yumi_o), 32'(oh));
    @(negedge clk);
    mem_yumi_i       = 1'b0;
    mem_resp_valid_i = 1'b1;
    resp_yumi_i      = oh;
    n_reset          = 1'b0;
    #1;
    chk("mid_rst_mresp_yumi", 32'(mem_resp_yumi_o), 0);
    chk("mid_rst_respv", 32'(resp_valid_o), 0);
    @(negedge clk);
    n_reset     = 1'b1;
    req_valid_i = '0;
    #1;
    chk("mid_after_busy", 32'(busy_o), 0);
    chk("mid_after_mresp_yumi", 32'(mem_resp_yumi_o), 0);
    chk("mid_after_respv", 32'(resp_valid_o), 0);
    chk("mid_after_memv", 32'(mem_valid_o), 0);
    chk("mid_after_rr", 32'(dut.rr_ptr_r), 0);
    rr = 0;
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    resp_yumi_i      = '0;
    do_txn(4'hF, 0, 0, 0, 1'b0, $urandom, g);
    chk("post_rst_grant", g, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
